// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad reader.
// Scan FSM states, code width and one-hot decode.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CANDIDATE = 2'd1,
        PRESSED   = 2'd2
    } state_e;

    localparam int IDXW = 5;

    typedef struct packed {
        logic            valid;
        logic [IDXW-1:0] idx;
    } oh_t;

    function automatic int code_width(input int cols, input int rows);
        int n;
        n = cols * rows;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Index of the single set bit; valid only when exactly one bit is set.
    function automatic oh_t onehot_index(input logic [31:0] v);
        oh_t r;
        r.valid = (v != '0) && ((v & (v - 32'd1)) == '0);
        r.idx   = '0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) r.idx = IDXW'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/keypad_reader_if.sv
// Key code valid/ready channel toward the consumer.
// master = keypad_reader, slave = consumer.
interface keypad_reader_if #(
    parameter int CW = 4
);
    logic [CW-1:0] key_code;
    logic          key_valid;
    logic          key_ready;

    modport master (
        output key_code,
        output key_valid,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        output key_ready
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs.
// Reset value is the inactive level of the lines.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    // Two-stage capture of the raw lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;
endmodule

// File: rtl/keypad_reader.sv
// Keypad receiver: samples rows per scanned column,
// debounces presses and emits one code per press.
module keypad_reader
    import keypad_pkg::*;
#(
    parameter int COLS           = 4,
    parameter int ROWS           = 4,
    parameter bit COL_ACTIVE_LOW = 1'b0,
    parameter bit ROW_ACTIVE_LOW = 1'b1,
    parameter int SETTLE         = 2,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int RELEASE_SCANS  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COLS-1:0]   col,
    input  logic [ROWS-1:0]   row,
    keypad_reader_if.master   kif,
    output logic              key_held,
    output logic              overflow
);
    localparam int CW  = code_width(COLS, ROWS);
    localparam int RIW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SCW = $clog2(SETTLE + 2);
    localparam int DW  = $clog2(DEBOUNCE_SCANS + 1);
    localparam int RW  = $clog2(RELEASE_SCANS + 1);
    localparam logic [ROWS-1:0] ROW_IDLE = ROW_ACTIVE_LOW ? '1 : '0;

    logic [ROWS-1:0] row_s;
    logic [ROWS-1:0] row_a;
    logic [COLS-1:0] col_c;
    logic [COLS-1:0] col_q;
    logic [SCW-1:0]  set_q, set_d;
    logic            chg;
    logic            strobe;
    oh_t             oh;
    logic            hit;
    logic [RIW-1:0]  s_row;

    state_e          state_q, state_d;
    logic [IDXW-1:0] cand_col_q, cand_col_d;
    logic [RIW-1:0]  cand_row_q, cand_row_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   rel_q, rel_d;
    logic            accept;
    logic [CW-1:0]   acc_code;

    logic [CW-1:0]   code_q, code_d;
    logic            valid_q, valid_d;
    logic            ovf_q, ovf_d;

    sync_2ff #(
        .WIDTH   (ROWS),
        .RST_VAL (ROW_IDLE)
    ) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d_i (row),
        .q_o (row_s)
    );

    assign row_a = ROW_ACTIVE_LOW ? ~row_s : row_s;
    assign col_c = COL_ACTIVE_LOW ? ~col : col;
    assign chg   = (col_c != col_q);
    assign oh    = onehot_index(32'(col_q));

    // Strobe fires once when the column has been stable SETTLE cycles.
    assign strobe = !chg && (set_q == SCW'(SETTLE)) && oh.valid;

    // Settle counter: restart on change, run to SETTLE+1 and park there.
    always_comb begin
        set_d = set_q;
        if (chg) begin
            set_d = SCW'(1);
        end else if (set_q != '0 && set_q <= SCW'(SETTLE)) begin
            set_d = set_q + SCW'(1);
        end
    end

    // Lowest-index active row wins.
    always_comb begin
        hit   = 1'b0;
        s_row = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (row_a[i]) begin
                hit   = 1'b1;
                s_row = RIW'(i);
            end
        end
    end

    assign acc_code = CW'(int'(oh.idx) * ROWS + int'(s_row));

    // Debounce FSM next state.
    always_comb begin
        state_d    = state_q;
        cand_col_d = cand_col_q;
        cand_row_d = cand_row_q;
        cnt_d      = cnt_q;
        rel_d      = rel_q;
        accept     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (strobe && hit) begin
                    cand_col_d = oh.idx;
                    cand_row_d = s_row;
                    rel_d      = '0;
                    if (DEBOUNCE_SCANS <= 1) begin
                        state_d = PRESSED;
                        accept  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = CANDIDATE;
                        cnt_d   = DW'(1);
                    end
                end
            end
            CANDIDATE: begin
                if (strobe && oh.idx == cand_col_q) begin
                    if (!hit) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (s_row != cand_row_q) begin
                        cand_row_d = s_row;
                        cnt_d      = DW'(1);
                    end else if (cnt_q + DW'(1) >= DW'(DEBOUNCE_SCANS)) begin
                        state_d = PRESSED;
                        accept  = 1'b1;
                        cnt_d   = '0;
                        rel_d   = '0;
                    end else begin
                        cnt_d = cnt_q + DW'(1);
                    end
                end
            end
            PRESSED: begin
                if (strobe && oh.idx == cand_col_q) begin
                    if (hit) begin
                        rel_d = '0;
                    end else if (rel_q + RW'(1) >= RW'(RELEASE_SCANS)) begin
                        state_d = IDLE;
                        rel_d   = '0;
                    end else begin
                        rel_d = rel_q + RW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register: load on accept if there is room, else flag overflow.
    always_comb begin
        code_d  = code_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (accept) begin
            if (!valid_q || kif.key_ready) begin
                code_d  = acc_code;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && kif.key_ready) begin
            valid_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            set_q      <= '0;
            state_q    <= IDLE;
            cand_col_q <= '0;
            cand_row_q <= '0;
            cnt_q      <= '0;
            rel_q      <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            col_q      <= col_c;
            set_q      <= set_d;
            state_q    <= state_d;
            cand_col_q <= cand_col_d;
            cand_row_q <= cand_row_d;
            cnt_q      <= cnt_d;
            rel_q      <= rel_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign kif.key_code  = code_q;
    assign kif.key_valid = valid_q;
    assign key_held      = (state_q == PRESSED);
    assign overflow      = ovf_q;
endmodule

// File: tb/tb_keypad_reader.sv
// Bench for keypad_reader: keypad matrix model,
// column sweep driver and code scoreboard.
module tb_keypad_reader;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] keys;
    logic        key_held;
    logic        overflow;

    int          tests = 0;
    int          fails = 0;
    int          held_cycles = 0;
    int          h0;
    logic [3:0]  exp_q[$];

    typedef struct {
        string       name;
        logic [15:0] keys;
        int          code;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    keypad_reader_if #(.CW(4)) kif();

    keypad_reader dut (
        .clk      (clk),
        .rst      (rst),
        .col      (col),
        .row      (row),
        .kif      (kif),
        .key_held (key_held),
        .overflow (overflow)
    );

    // Matrix model: a pressed key pulls its row low when its column is driven.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (col[c] && keys[c*4+r]) row[r] = 1'b0;
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // Scoreboard: every transfer must match the next expected code.
    always @(negedge clk) begin
        if (key_held) held_cycles++;
        if (!rst && kif.key_valid && kif.key_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_key: got code %0d required none",
                         kif.key_code);
            end else begin
                check("key_code", 32'(kif.key_code), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scan(int n);
        repeat (n) begin
            for (int c = 0; c < 4; c++) begin
                col = 4'b0001 << c;
                repeat (6) tick();
            end
        end
    endtask

    initial begin
        vecs[0] = '{"k9",  16'h0200, 9};
        vecs[1] = '{"k0",  16'h0001, 0};
        vecs[2] = '{"k15", 16'h8000, 15};
        vecs[3] = '{"k4m", 16'h0050, 4};
        vecs[4] = '{"k7",  16'h0080, 7};
        vecs[5] = '{"k14", 16'h4000, 14};

        rst           = 1'b1;
        keys          = '0;
        col           = '0;
        kif.key_ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", 32'(kif.key_valid), 0);
        check("rst_code",  32'(kif.key_code), 0);
        check("rst_held",  32'(key_held), 0);
        check("rst_ovf",   32'(overflow), 0);
        rst = 1'b0;
        scan(4);
        check("idle_valid", 32'(kif.key_valid), 0);

        foreach (vecs[i]) begin
            keys = vecs[i].keys;
            exp_q.push_back(4'(vecs[i].code));
            scan(5);
            check({vecs[i].name, "_held"}, 32'(key_held), 1);
            keys = '0;
            scan(2);
            check({vecs[i].name, "_held2"}, 32'(key_held), 1);
            scan(1);
            check({vecs[i].name, "_rel"}, 32'(key_held), 0);
            check({vecs[i].name, "_drain"}, 32'(exp_q.size()), 0);
            check({vecs[i].name, "_valid"}, 32'(kif.key_valid), 0);
        end

        h0 = held_cycles;
        for (int i = 0; i < 6; i++) begin
            keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
            scan(1);
        end
        check("bounce_held", 32'(held_cycles - h0), 0);
        keys = 16'h0200;
        exp_q.push_back(4'd9);
        scan(4);
        check("bounce_press", 32'(key_held), 1);
        keys = '0;
        scan(3);
        check("bounce_drain", 32'(exp_q.size()), 0);

        h0   = held_cycles;
        keys = 16'h0020;
        col  = 4'b0110;
        repeat (20) tick();
        check("nonoh_held", 32'(held_cycles - h0), 0);
        check("nonoh_valid", 32'(kif.key_valid), 0);
        keys = '0;
        scan(1);

        kif.key_ready = 1'b0;
        keys = 16'h0001;
        exp_q.push_back(4'd0);
        scan(5);
        keys = '0;
        scan(4);
        keys = 16'h8000;
        scan(5);
        keys = '0;
        scan(4);
        check("ovf_valid", 32'(kif.key_valid), 1);
        check("ovf_code",  32'(kif.key_code), 0);
        check("ovf_flag",  32'(overflow), 1);
        kif.key_ready = 1'b1;
        tick();
        tick();
        check("ovf_drained", 32'(kif.key_valid), 0);
        check("ovf_queue", 32'(exp_q.size()), 0);
        check("ovf_sticky", 32'(overflow), 1);

        keys = 16'h0020;
        exp_q.push_back(4'd5);
        scan(4);
        check("k5_held", 32'(key_held), 1);
        rst = 1'b1;
        tick();
        check("mid_rst_held",  32'(key_held), 0);
        check("mid_rst_valid", 32'(kif.key_valid), 0);
        check("mid_rst_code",  32'(kif.key_code), 0);
        check("mid_rst_ovf",   32'(overflow), 0);
        rst = 1'b0;
        exp_q.push_back(4'd5);
        scan(4);
        check("k5_reheld", 32'(key_held), 1);
        check("k5_queue", 32'(exp_q.size()), 0);
        keys = '0;
        scan(3);
        check("k5_rel", 32'(key_held), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/keypad_reader.md
Name: keypad_reader

Overview:
- Receiving end of the keypad column sweep. Watches the one-hot column bus driven by the column scanner and the keypad row lines, and finds which key is pressed.
- Debounces the press over repeated scans and delivers one key code per press on a valid/ready output to the display/control logic.
- Sits between the keypad pins plus the scanner and the downstream consumer.

Parameters:
- COLS, 4, number of keypad columns (must match the scanner WIDTH).
- ROWS, 4, number of keypad row inputs.
- COL_ACTIVE_LOW, 1'b0, col input is active-low when 1 (inverted internally).
- ROW_ACTIVE_LOW, 1'b1, row input is active-low when 1 (pull-ups on the pins).
- SETTLE, 2, clk cycles after a column change before rows are sampled.
- DEBOUNCE_SCANS, 3, consecutive confirming samples needed to accept a key.
- RELEASE_SCANS, 3, consecutive empty samples needed to declare release.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- col  in  COLS  column bus from the scanner; one-hot after polarity correction.
- row  in  ROWS  raw asynchronous row lines from the keypad.
- key_code  out  CW=$clog2(COLS*ROWS)  code of the accepted key = col_idx*ROWS + row_idx.
- key_valid  out  1  key_code holds an unconsumed key.
- key_ready  in  1  consumer accepts key_code when high together with key_valid.
- key_held  out  1  high while the FSM is in PRESSED.
- overflow  out  1  sticky; set when a key is accepted while the output is still full.

Behaviour:
- Reset (rst=1 at a clk edge): FSM=IDLE, counters=0, synchroniser flops=inactive. All outputs=0 (key_code=0).
- Rows pass through a 2-flop synchroniser, then polarity correction.
- Column change detect: col register compared each cycle; any change restarts the settle counter.
- Sample strobe: one pulse exactly SETTLE cycles after the change, provided col is still unchanged and one-hot. A col that is not one-hot produces no strobe.
- Scanner requirement: scanner WAIT_TIME+1 >= SETTLE+3.
- Sample content: active column index plus the lowest-index active row; hit=0 if no row is active.
- FSM IDLE:
  - strobe with hit -> CANDIDATE; latch cand_col/cand_row; cnt=1.
- FSM CANDIDATE (only strobes for cand_col are considered; other columns are ignored):
  - same row -> cnt+1; when cnt reaches DEBOUNCE_SCANS -> PRESSED and accept the key.
  - different row -> relatch the new row, cnt=1.
  - no hit -> IDLE.
  - With DEBOUNCE_SCANS=1, acceptance happens on the first strobe (IDLE -> PRESSED directly).
- FSM PRESSED:
  - strobe for cand_col with no hit -> rel+1; reaching RELEASE_SCANS -> IDLE.
  - strobe for cand_col with a hit -> rel=0.
  - No repeat codes while held; a second key pressed during PRESSED is ignored.
- Accept event:
  - output empty, or key_ready high in the same cycle -> load key_code, key_valid=1.
  - otherwise -> drop the new key, set overflow=1.
  - overflow clears only on rst.
- Output handshake:
  - key_valid && key_ready at an edge clears key_valid, unless an accept loads the output in the same cycle.
  - key_code stays stable while key_valid=1 and no transfer occurs.
- Latency: key_valid rises 1 cycle after the accepting strobe.
- Reset mid-press: returns to IDLE. If the key is still held, it is re-detected and re-emitted after a full debounce.

Decomposition:
- keypad_pkg: state enum (IDLE, CANDIDATE, PRESSED); function code_width(cols,rows); function onehot_index returning index plus a valid flag.
- One sub-module: sync_2ff (parameterised width, reset value) for the row lines.

Test Plan:
- Reset with all rows inactive (row=4'hF, ROW_ACTIVE_LOW) -> outputs 0; no key_valid over 4 full scans.
- Press col 2/row 1 steady for 3 scans, key_ready=1 -> exactly one key_valid pulse with key_code=9; key_held=1 until 3 empty samples of col 2 after release.
- Bounce: row toggles on alternate col-2 strobes -> FSM never reaches PRESSED, no key_valid; then held steady -> code emitted after 3 consecutive hits.
- key_ready=0: press 0/0, release, press 3/3 -> key_code stays 0 with key_valid=1, overflow=1; raise key_ready -> key_valid falls, no code 15 appears.
- Row 0 and row 2 active on col 1 at once -> key_code=4 (lowest row wins); non-one-hot col=4'b0110 for 20 cycles -> no state change.
- Assert rst during PRESSED for key 5 -> IDLE, outputs 0; key still held -> code 5 re-emitted after 3 scans.
